// File: rtl/ling_arb_pkg.sv
// Shared types and the round-robin grant function for the shared Ling adder arbiter.
// Operands are fixed at 64 bits, and request ids are at most 3 bits wide (up to 8 requesters).
package ling_arb_pkg;

  localparam int WIDTH_C  = 64;
  localparam int NREQ_MAX = 8;
  localparam int IDW_MAX  = 3;

  typedef struct packed {
    logic [WIDTH_C-1:0] a;
    logic [WIDTH_C-1:0] b;
    logic [IDW_MAX-1:0] id;
  } op_t;

  typedef struct packed {
    logic [WIDTH_C-1:0] sum;
    logic [IDW_MAX-1:0] id;
  } rsp_t;

  // Returns a one-hot grant. The scan starts one past ptr and wraps modulo nreq.
  function automatic logic [NREQ_MAX-1:0] rr_next(input logic [NREQ_MAX-1:0] req,
                                                  input logic [IDW_MAX-1:0]  ptr,
                                                  input int                  nreq);
    logic [NREQ_MAX-1:0] grant;
    int                  idx;
    grant = '0;
    for (int k = 1; k <= NREQ_MAX; k++) begin
      if (k <= nreq) begin
        idx = (int'(ptr) + k) % nreq;
        if (grant == '0 && req[idx]) grant[idx] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/J4x4x4_adder.sv
// 64-bit combinational adder with three levels of 4-way grouped carry lookahead (4x4x4).
// The group terms use the Ling transmit signal t = a|b. There is no carry-in.
module J4x4x4_adder (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum
);

  logic [63:0] g, t, p, c;
  logic [15:0] g1, t1, c1;
  logic [3:0]  g2, t2, c2;
  logic        unused_top;

  function automatic logic [1:0] grp4(input logic [3:0] gi, input logic [3:0] ti);
    logic gg;
    gg = gi[3] | (ti[3] & gi[2]) | (ti[3] & ti[2] & gi[1]) | (ti[3] & ti[2] & ti[1] & gi[0]);
    return {gg, &ti};
  endfunction

  always_comb begin
    g = a & b;
    t = a | b;
    p = a ^ b;
    for (int k = 0; k < 16; k++) {g1[k], t1[k]} = grp4(g[4*k +: 4], t[4*k +: 4]);
    for (int m = 0; m < 4; m++)  {g2[m], t2[m]} = grp4(g1[4*m +: 4], t1[4*m +: 4]);
    c2[0] = 1'b0;
    for (int m = 1; m < 4; m++)  c2[m] = g2[m-1] | (t2[m-1] & c2[m-1]);
    for (int k = 0; k < 16; k++) c1[k] = (k % 4 == 0) ? c2[k/4] : (g1[k-1] | (t1[k-1] & c1[k-1]));
    for (int i = 0; i < 64; i++) c[i]  = (i % 4 == 0) ? c1[i/4] : (g[i-1] | (t[i-1] & c[i-1]));
    sum = p ^ c;
  end

  // The carry out of the top block is not needed, because the sum is taken mod 2^64.
  assign unused_top = g2[3] ^ t2[3];

endmodule

// File: rtl/ling_rr_arbiter.sv
// Combinational round-robin arbiter. It returns a one-hot grant and the encoded index.
// When enable is low, the grant is forced to zero.
module ling_rr_arbiter
  import ling_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic [NREQ_MAX-1:0] req_ext;
  logic [NREQ_MAX-1:0] grant_all;
  logic [IDW_MAX-1:0]  ptr_ext;
  logic                unused_grant;

  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req;
    ptr_ext             = '0;
    ptr_ext[IDW-1:0]    = ptr;
    grant_all           = rr_next(req_ext, ptr_ext, NREQ);
    grant               = enable ? grant_all[NREQ-1:0] : '0;
    idx                 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_all[i]) idx = IDW'(i);
    end
  end

  assign unused_grant = ^grant_all;

endmodule

// File: rtl/ling_add_arbiter.sv
// Round-robin share of one 64-bit Ling adder: arbitration -> operand reg -> sum reg -> tagged rsp.
// Handshake-to-rsp_valid latency is 2 cycles. LING_ADD_ARB_FLAGS_EN adds the rsp_cout/rsp_ovf outputs.
module ling_add_arbiter
  import ling_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic [IDW-1:0]        rsp_id
`ifdef LING_ADD_ARB_FLAGS_EN
  ,
  output logic                  rsp_cout,
  output logic                  rsp_ovf
`endif
);

  logic [IDW-1:0]     ptr_q, ptr_d;
  op_t                s1_q, s1_d;
  logic               s1_valid_q, s1_valid_d;
  rsp_t               s2_q, s2_d;
  logic               s2_valid_q, s2_valid_d;
  logic               advance, accept, hs;
  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     grant_idx;
  logic [WIDTH_C-1:0] sum;
  logic               unused_id;
`ifdef LING_ADD_ARB_FLAGS_EN
  logic               cout_q, cout_d, ovf_q, ovf_d;
`endif

  // Reset also masks the grant, so a requester that holds valid during reset is not accepted.
  ling_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .enable (accept & ~rst),
    .grant  (grant),
    .idx    (grant_idx)
  );

  J4x4x4_adder u_add (
    .a   (s1_q.a),
    .b   (s1_q.b),
    .sum (sum)
  );

  always_comb begin
    advance    = ~s2_valid_q | rsp_ready;
    accept     = ~s1_valid_q | advance;
    hs         = |(req_valid & grant);
    ptr_d      = ptr_q;
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    if (hs) begin
      s1_d.a              = req_a[int'(grant_idx)*WIDTH +: WIDTH];
      s1_d.b              = req_b[int'(grant_idx)*WIDTH +: WIDTH];
      s1_d.id             = '0;
      s1_d.id[IDW-1:0]    = grant_idx;
      s1_valid_d          = 1'b1;
      ptr_d               = grant_idx;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end
    if (advance) begin
      s2_d.sum   = sum;
      s2_d.id    = s1_q.id;
      s2_valid_d = s1_valid_q;
    end
  end

`ifdef LING_ADD_ARB_FLAGS_EN
  always_comb begin
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (advance) begin
      cout_d = (s1_q.a[63] & s1_q.b[63]) | ((s1_q.a[63] ^ s1_q.b[63]) & ~sum[63]);
      ovf_d  = (s1_q.a[63] == s1_q.b[63]) & (sum[63] != s1_q.a[63]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign rsp_cout = cout_q;
  assign rsp_ovf  = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= IDW'(NREQ - 1);
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_q       <= s2_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = s2_valid_q;
  assign rsp_sum   = s2_q.sum;
  assign rsp_id    = s2_q.id[IDW-1:0];
  assign unused_id = ^s2_q.id;

endmodule

// File: tb/tb_ling_add_arbiter.sv
// Directed bench for ling_add_arbiter. It checks reset, latency, wraparound, fairness, stall and reset mid-flight.
// Inputs are driven and outputs are sampled around the falling edge of clk.
module tb_ling_add_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic            rsp_valid, rsp_ready;
  logic [W-1:0]    rsp_sum;
  logic [IDW-1:0]  rsp_id;
`ifdef LING_ADD_ARB_FLAGS_EN
  logic            rsp_cout, rsp_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ling_add_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
`ifdef LING_ADD_ARB_FLAGS_EN
    ,
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic chk_rsp(input string tag, input logic [63:0] sum, input logic [IDW-1:0] id);
    chk({tag, "_vld"}, {63'd0, rsp_valid}, 64'd1);
    chk({tag, "_sum"}, rsp_sum, sum);
    chk({tag, "_id"}, {62'd0, rsp_id}, {62'd0, id});
  endtask

  task automatic chk_flags(input string tag, input logic cout, input logic ovf);
`ifdef LING_ADD_ARB_FLAGS_EN
    chk({tag, "_cout"}, {63'd0, rsp_cout}, {63'd0, cout});
    chk({tag, "_ovf"}, {63'd0, rsp_ovf}, {63'd0, ovf});
`else
    if (tag.len() == 0) $display("empty flag tag cout=%0b ovf=%0b", cout, ovf);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;

    // Reset: all outputs are zero, and no grant is given even though every requester is valid.
    cyc();
    cyc();
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_sum", rsp_sum, 64'd0);
    chk("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
    chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
    chk_flags("rst", 1'b0, 1'b0);
    rst       = 1'b0;
    req_valid = 4'h0;

    // Single op: 5 + 7 from requester 0. The response appears two edges after the handshake.
    cyc();
    set_op(0, 64'h5, 64'h7);
    req_valid = 4'b0001;
    #1 chk("single_grant", {60'd0, req_ready}, 64'b0001);
    cyc();
    req_valid = 4'b0000;
    chk("single_lat1_vld", {63'd0, rsp_valid}, 64'd0);
    cyc();
    chk_rsp("single", 64'hC, 2'd0);
    chk_flags("single", 1'b0, 1'b0);

    // Unsigned wraparound from requester 2.
    set_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    req_valid = 4'b0100;
    #1 chk("wrap_grant", {60'd0, req_ready}, 64'b0100);
    cyc();
    req_valid = 4'b0000;
    cyc();
    chk_rsp("wrap", 64'h0, 2'd2);
    chk_flags("wrap", 1'b1, 1'b0);

    // Signed overflow from requester 3.
    set_op(3, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    req_valid = 4'b1000;
    #1 chk("ovf_grant", {60'd0, req_ready}, 64'b1000);
    cyc();
    req_valid = 4'b0000;
    cyc();
    chk_rsp("ovf", 64'h8000_0000_0000_0000, 2'd3);
    chk_flags("ovf", 1'b0, 1'b1);

    // Fairness: all requesters stay valid. Grants rotate 0,1,2,3,..., and one result arrives per cycle.
    for (int i = 0; i < NREQ; i++) set_op(i, 64'(i), 64'h100);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("fair_grant%0d", k), {60'd0, req_ready}, 64'(1 << (k % 4)));
      if (k >= 2) chk_rsp($sformatf("fair_rsp%0d", k), 64'h100 + 64'((k - 2) % 4), 2'((k - 2) % 4));
      cyc();
    end
    req_valid = 4'h0;
    cyc();
    cyc();
    chk("fair_drain_vld", {63'd0, rsp_valid}, 64'd0);

    // Backpressure: two ops are in flight while the consumer stalls for 5 cycles.
    rsp_ready = 1'b0;
    set_op(0, 64'h10, 64'h1);
    set_op(1, 64'h20, 64'h2);
    set_op(2, 64'h30, 64'h3);
    req_valid = 4'b0011;
    #1 chk("bp_grant0", {60'd0, req_ready}, 64'b0001);
    cyc();
    req_valid = 4'b0010;
    #1 chk("bp_grant1", {60'd0, req_ready}, 64'b0010);
    cyc();
    req_valid = 4'b0100;
    #1 chk("bp_full_ready", {60'd0, req_ready}, 64'd0);
    chk_rsp("bp_hold0", 64'h11, 2'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_rsp($sformatf("bp_stall%0d", k), 64'h11, 2'd0);
      chk($sformatf("bp_stall_ready%0d", k), {60'd0, req_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_grant", {60'd0, req_ready}, 64'b0100);
    cyc();
    req_valid = 4'b0000;
    chk_rsp("bp_out1", 64'h22, 2'd1);
    cyc();
    chk_rsp("bp_out2", 64'h33, 2'd2);
    cyc();
    chk("bp_done_vld", {63'd0, rsp_valid}, 64'd0);

    // Reset mid-flight: S1 and S2 both hold ops when rst is asserted.
    rsp_ready = 1'b0;
    set_op(0, 64'h40, 64'h4);
    set_op(1, 64'h50, 64'h5);
    req_valid = 4'b0001;
    #1 chk("mid_grant0", {60'd0, req_ready}, 64'b0001);
    cyc();
    req_valid = 4'b0010;
    #1 chk("mid_grant1", {60'd0, req_ready}, 64'b0010);
    cyc();
    req_valid = 4'b0000;
    chk_rsp("mid_pre", 64'h44, 2'd0);
    rst       = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) set_op(i, 64'h200 + 64'(i), 64'h0);
    cyc();
    chk("mid_rst_vld", {63'd0, rsp_valid}, 64'd0);
    chk("mid_rst_ready", {60'd0, req_ready}, 64'd0);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    #1 chk("mid_first_grant", {60'd0, req_ready}, 64'b0001);
    cyc();
    req_valid = 4'hE;
    #1 chk("mid_second_grant", {60'd0, req_ready}, 64'b0010);
    cyc();
    req_valid = 4'hC;
    chk_rsp("mid_out0", 64'h200, 2'd0);
    cyc();
    req_valid = 4'h8;
    chk_rsp("mid_out1", 64'h201, 2'd1);
    cyc();
    req_valid = 4'h0;
    chk_rsp("mid_out2", 64'h202, 2'd2);
    cyc();
    chk_rsp("mid_out3", 64'h203, 2'd3);
    cyc();
    chk("mid_end_vld", {63'd0, rsp_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
